interrupt_request_ctrl: RTL and testbench
=========================================

// Module: interrupt_request_ctrl
// PURPOSE
// Upstream front end for the CPU interrupt handler. Latches the reset, NMI, BRK and IRQ
// sources and prioritises them at instruction boundaries. Offers one request at a time,
// with its vector address and pushed-B flag, over a valid/ack handshake.
// The handler consumes the request and pulses done when the vector sequence completes.
// PARAMETERS
// RESET_HOLD  4        consecutive low cycles of soft_reset_n needed to latch a soft reset (>=1)
// VEC_NMI     16'hFFFA NMI vector low-byte address
// VEC_RESET   16'hFFFC reset vector low-byte address
// VEC_IRQ     16'hFFFE IRQ/BRK vector low-byte address
// PORTS
// clk            in   1   system clock, all logic on rising edge
// rst            in   1   asynchronous, active-low reset
// ppu_vblank     in   1   PPU status bit 7 (vblank)
// nmi_enable     in   1   PPUCTRL bit 7; NMI line = ppu_vblank & nmi_enable
// irq_n          in   1   level IRQ from APU/mapper, active low
// soft_reset_n   in   1   console reset button, active low
// break_flag     in   1   current instruction is BRK (valid while poll=1)
// i_flag         in   1   CPU status bit 2 (interrupt disable)
// poll           in   1   one-cycle strobe from executor at instruction boundary
// req_valid      out  1   request offered to handler
// req_kind       out  2   0=reset 1=NMI 2=BRK 3=IRQ
// req_vector     out  16  vector low-byte address for req_kind
// req_b_flag     out  1   B bit for the pushed status (1 only for BRK)
// req_ack        in   1   handler accepts request (start)
// handler_done   in   1   handler finished, one-cycle pulse
// busy           out  1   request offered or in service
// nmi_pending    out  1   NMI edge latched, not yet acknowledged
// BEHAVIOUR
// - Reset values: req_valid=0, req_kind=0, req_vector=0, req_b_flag=0, busy=0,
//   nmi_pending=0, hold counter=0, NMI line history=0, state=IDLE; reset pending flag=1,
//   so the first poll after reset release offers the reset vector.
// - NMI: registered copy of the NMI line; a 0->1 transition sets nmi_pending. Level high
//   alone never re-triggers. A set in the same cycle as its clear wins; the new edge stays pending.
// - Soft reset: saturating counter increments while soft_reset_n=0 and clears to 0 when it is 1.
//   When the counter reaches RESET_HOLD the reset flag sets, once per press.
// - IRQ and BRK are not latched; they are sampled only on the poll cycle. IRQ is eligible
//   when irq_n=0 and i_flag=0. BRK is eligible when break_flag=1 and ignores i_flag.
// - Priority at poll: reset > NMI > BRK > IRQ. No eligible source means no action.
// - FSM IDLE: when poll=1 and a source is eligible, load req_kind, req_vector and req_b_flag;
//   set req_valid=1 next cycle (1-cycle latency); go to OFFER. poll is ignored outside IDLE.
// - FSM OFFER: outputs are frozen; a later higher-priority arrival does not preempt.
//   On req_ack=1: req_valid=0 next cycle; clear the reset flag or nmi_pending if that is
//   the kind; go to SERVICE. Holds indefinitely without ack.
// - FSM SERVICE: on handler_done=1 go to IDLE and clear req_kind, req_vector and req_b_flag to 0.
//   A poll in the same cycle as done is ignored.
// - busy=1 in OFFER and SERVICE.
// - Sources arriving during OFFER or SERVICE: NMI and reset stay latched for the next poll.
//   IRQ/BRK not present at that poll are lost; this is by design, because the executor re-polls.
// - Illegal state: go to IDLE with the reset values, but leave the pending flags unchanged.
// - rst asserted mid-operation: everything returns to the reset values immediately,
//   including reset pending=1.
// TESTING
// - Release rst, poll at cycle 3 -> req_valid at cycle 4, kind=0, vector=FFFC; ack -> valid=0, pending cleared.
// - nmi_enable=1, vblank 0->1 held 100 cycles, poll -> one NMI offer FFFA; after ack/done another poll -> no offer.
// - At poll: irq_n=0, i_flag=0, break_flag=1, NMI pending -> kind=1; after done, a poll with
//   irq_n=0 and break_flag=1 -> kind=2, b_flag=1.
// - irq_n=0, i_flag=1, poll -> no offer; i_flag=0, poll -> kind=3, vector=FFFE, b_flag=0.
// - soft_reset_n low for 3 cycles -> no latch; low for 4 cycles -> reset offered at next poll.
// - NMI edge in the same cycle as the NMI ack -> nmi_pending stays 1; rst pulsed while in SERVICE ->
//   IDLE and reset pending=1.

Source files
------------

// File: rtl/interrupt_request_ctrl.sv
// Interrupt request front end: latches reset/NMI, samples BRK/IRQ at poll, and offers
// the highest-priority request with its vector over a valid/ack handshake.
module interrupt_request_ctrl #(
    parameter int unsigned RESET_HOLD = 4,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RESET  = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ppu_vblank,
    input  logic        nmi_enable,
    input  logic        irq_n,
    input  logic        soft_reset_n,
    input  logic        break_flag,
    input  logic        i_flag,
    input  logic        poll,
    output logic        req_valid,
    output logic [1:0]  req_kind,
    output logic [15:0] req_vector,
    output logic        req_b_flag,
    input  logic        req_ack,
    input  logic        handler_done,
    output logic        busy,
    output logic        nmi_pending
);
    localparam int CW = $clog2(RESET_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(RESET_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);

    localparam logic [1:0] K_RESET = 2'd0;
    localparam logic [1:0] K_NMI   = 2'd1;
    localparam logic [1:0] K_BRK   = 2'd2;
    localparam logic [1:0] K_IRQ   = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, SERVICE = 2'd2} state_t;

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic            nmi_hist;
    logic            reset_pend;
    logic            nmi_line, nmi_edge, hold_hit;
    logic            clr_nmi, clr_reset;
    logic            any_src;
    logic [1:0]      sel_kind;
    logic [15:0]     sel_vec;

    assign nmi_line  = ppu_vblank & nmi_enable;
    assign nmi_edge  = nmi_line & ~nmi_hist;
    // Fires only on the step into saturation, so a long press latches once.
    assign hold_hit  = ~soft_reset_n && (hold_cnt == HOLD_LAST);
    assign clr_nmi   = (state == OFFER) && req_ack && (req_kind == K_NMI);
    assign clr_reset = (state == OFFER) && req_ack && (req_kind == K_RESET);

    always_comb begin
        any_src  = 1'b1;
        sel_kind = K_IRQ;
        if (reset_pend)              sel_kind = K_RESET;
        else if (nmi_pending)        sel_kind = K_NMI;
        else if (break_flag)         sel_kind = K_BRK;
        else if (!irq_n && !i_flag)  sel_kind = K_IRQ;
        else                         any_src  = 1'b0;
        case (sel_kind)
            K_RESET: sel_vec = VEC_RESET;
            K_NMI:   sel_vec = VEC_NMI;
            default: sel_vec = VEC_IRQ;
        endcase
    end

    // Pending sources; a new set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt    <= '0;
            nmi_hist    <= 1'b0;
            nmi_pending <= 1'b0;
            reset_pend  <= 1'b1;
        end else begin
            nmi_hist    <= nmi_line;
            nmi_pending <= nmi_edge | (nmi_pending & ~clr_nmi);
            reset_pend  <= hold_hit | (reset_pend & ~clr_reset);
            if (soft_reset_n)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_valid  <= 1'b0;
            req_kind   <= 2'd0;
            req_vector <= 16'h0000;
            req_b_flag <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (poll && any_src) begin
                        req_kind   <= sel_kind;
                        req_vector <= sel_vec;
                        req_b_flag <= (sel_kind == K_BRK);
                        req_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (req_ack) begin
                        req_valid <= 1'b0;
                        state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (handler_done) begin
                        req_kind   <= 2'd0;
                        req_vector <= 16'h0000;
                        req_b_flag <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    req_valid  <= 1'b0;
                    req_kind   <= 2'd0;
                    req_vector <= 16'h0000;
                    req_b_flag <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Directed and randomized checks of interrupt_request_ctrl against a cycle-level
// behavioural model of the request rules.
module tb_interrupt_request_ctrl;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ppu_vblank, nmi_enable, irq_n, soft_reset_n, break_flag, i_flag, poll;
    logic        req_ack, handler_done;
    logic        req_valid, req_b_flag, busy, nmi_pending;
    logic [1:0]  req_kind;
    logic [15:0] req_vector;

    int vectors = 0;
    int miscompares = 0;

    // model state
    bit          m_rst_pend, m_nmi_pend, m_line_prev, m_valid, m_b;
    int          m_hold, m_phase, m_kind;
    logic [15:0] m_vec;
    logic [15:0] vec_tab [4] = '{16'hFFFC, 16'hFFFA, 16'hFFFE, 16'hFFFE};

    interrupt_request_ctrl dut (
        .clk(clk), .rst(rst), .ppu_vblank(ppu_vblank), .nmi_enable(nmi_enable),
        .irq_n(irq_n), .soft_reset_n(soft_reset_n), .break_flag(break_flag),
        .i_flag(i_flag), .poll(poll), .req_valid(req_valid), .req_kind(req_kind),
        .req_vector(req_vector), .req_b_flag(req_b_flag), .req_ack(req_ack),
        .handler_done(handler_done), .busy(busy), .nmi_pending(nmi_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rst_pend = 1; m_nmi_pend = 0; m_line_prev = 0; m_valid = 0; m_b = 0;
        m_hold = 0; m_phase = 0; m_kind = 0; m_vec = 16'h0;
    endtask

    // phase: 0 waiting for poll, 1 request offered, 2 handler running
    task automatic model_step();
        bit line, set_nmi, set_rst, clr_nmi, clr_rst;
        int pick;
        line    = ppu_vblank & nmi_enable;
        set_nmi = line && !m_line_prev;
        set_rst = 0; clr_nmi = 0; clr_rst = 0;
        if (soft_reset_n) m_hold = 0;
        else if (m_hold < HOLD) begin
            m_hold++;
            if (m_hold == HOLD) set_rst = 1;
        end
        if (m_phase == 0 && poll) begin
            pick = m_rst_pend ? 0 : m_nmi_pend ? 1 : break_flag ? 2 :
                   (!irq_n && !i_flag) ? 3 : -1;
            if (pick >= 0) begin
                m_kind = pick; m_vec = vec_tab[pick]; m_b = (pick == 2);
                m_valid = 1; m_phase = 1;
            end
        end else if (m_phase == 1 && req_ack) begin
            m_valid = 0; m_phase = 2;
            clr_rst = (m_kind == 0);
            clr_nmi = (m_kind == 1);
        end else if (m_phase == 2 && handler_done) begin
            m_phase = 0; m_kind = 0; m_vec = 16'h0; m_b = 0;
        end
        m_line_prev = line;
        m_nmi_pend  = set_nmi ? 1'b1 : (clr_nmi ? 1'b0 : m_nmi_pend);
        m_rst_pend  = set_rst ? 1'b1 : (clr_rst ? 1'b0 : m_rst_pend);
    endtask

    task automatic check_all();
        chk("valid", {15'd0, req_valid}, {15'd0, m_valid});
        chk("kind", {14'd0, req_kind}, 16'(m_kind));
        chk("vector", req_vector, m_vec);
        chk("b_flag", {15'd0, req_b_flag}, {15'd0, m_b});
        chk("busy", {15'd0, busy}, {15'd0, m_phase != 0});
        chk("nmi_pending", {15'd0, nmi_pending}, {15'd0, m_nmi_pend});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_poll();
        poll = 1; cycle(); poll = 0;
    endtask

    task automatic ack_done();
        req_ack = 1; cycle(); req_ack = 0;
        handler_done = 1; cycle(); handler_done = 0;
    endtask

    initial begin
        rst = 0; ppu_vblank = 0; nmi_enable = 0; irq_n = 1; soft_reset_n = 1;
        break_flag = 0; i_flag = 1; poll = 0; req_ack = 0; handler_done = 0;
        model_reset();
        #3;
        check_all();
        chk("rst_valid", {15'd0, req_valid}, 16'd0);
        @(negedge clk); rst = 1;

        // reset vector offered from the power-on pending flag
        cycle(); cycle();
        do_poll();
        chk("rv_valid", {15'd0, req_valid}, 16'd1);
        chk("rv_vector", req_vector, 16'hFFFC);
        req_ack = 1; cycle(); req_ack = 0;
        chk("rv_ack_valid", {15'd0, req_valid}, 16'd0);
        handler_done = 1; cycle(); handler_done = 0;
        chk("rv_done_busy", {15'd0, busy}, 16'd0);

        // long vblank gives exactly one NMI
        nmi_enable = 1; ppu_vblank = 1;
        repeat (100) cycle();
        do_poll();
        chk("nmi_kind", {14'd0, req_kind}, 16'd1);
        chk("nmi_vector", req_vector, 16'hFFFA);
        ack_done();
        do_poll();
        chk("nmi_once", {15'd0, req_valid}, 16'd0);
        ppu_vblank = 0; cycle();

        // NMI beats BRK and IRQ; then BRK beats IRQ
        ppu_vblank = 1; cycle();
        irq_n = 0; i_flag = 0; break_flag = 1;
        do_poll();
        chk("prio_nmi", {14'd0, req_kind}, 16'd1);
        ack_done();
        do_poll();
        chk("prio_brk", {14'd0, req_kind}, 16'd2);
        chk("brk_b", {15'd0, req_b_flag}, 16'd1);
        ack_done();
        break_flag = 0;

        // IRQ masked by i_flag, then taken
        i_flag = 1;
        do_poll();
        chk("irq_masked", {15'd0, req_valid}, 16'd0);
        i_flag = 0;
        do_poll();
        chk("irq_kind", {14'd0, req_kind}, 16'd3);
        chk("irq_vector", req_vector, 16'hFFFE);
        chk("irq_b", {15'd0, req_b_flag}, 16'd0);
        ack_done();
        irq_n = 1; i_flag = 1;

        // soft reset hold threshold
        soft_reset_n = 0; repeat (HOLD - 1) cycle(); soft_reset_n = 1; cycle();
        do_poll();
        chk("sr_short", {15'd0, req_valid}, 16'd0);
        soft_reset_n = 0; repeat (HOLD) cycle(); soft_reset_n = 1; cycle();
        do_poll();
        chk("sr_kind", {14'd0, req_kind}, 16'd0);
        chk("sr_valid", {15'd0, req_valid}, 16'd1);
        ack_done();

        // NMI edge coinciding with NMI ack stays pending
        ppu_vblank = 0; cycle();
        ppu_vblank = 1; cycle();
        ppu_vblank = 0; cycle();
        do_poll();
        chk("edge_kind", {14'd0, req_kind}, 16'd1);
        ppu_vblank = 1; req_ack = 1; cycle(); req_ack = 0;
        chk("edge_keep", {15'd0, nmi_pending}, 16'd1);

        // async reset while in service
        cycle();
        rst = 0; #2;
        model_reset();
        check_all();
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        rst = 1;
        cycle();
        do_poll();
        chk("mid_rst_kind", {14'd0, req_kind}, 16'd0);
        chk("mid_rst_vec", req_vector, 16'hFFFC);
        ack_done();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ppu_vblank   = ($urandom_range(0, 9) < 2) ? ~ppu_vblank : ppu_vblank;
            nmi_enable   = ($urandom_range(0, 9) < 8);
            irq_n        = $urandom_range(0, 1);
            i_flag       = $urandom_range(0, 1);
            break_flag   = ($urandom_range(0, 9) < 2);
            soft_reset_n = ($urandom_range(0, 9) < 1) ? ~soft_reset_n : soft_reset_n;
            poll         = ($urandom_range(0, 9) < 3);
            req_ack      = ($urandom_range(0, 9) < 3);
            handler_done = ($urandom_range(0, 9) < 2);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
